afu_tlx_cmd_arb: RTL and testbench

//  Round-robin arbiter and credit scheduler for the AFU->TLX command/cdata transmit interface.

---
 rtl/afu_tlx_cmd_arb_if.sv | 46 ++++
 rtl/afu_tlx_cmd_arb.sv | 206 ++++++++++++++++++++
 tb/tb_afu_tlx_cmd_arb.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/afu_tlx_cmd_arb_if.sv
// ============================================================================
// Module   : afu_tlx_cmd_arb_if
// Brief    : AFU->TLX command/cdata arbitration bundle (requesters, credits,
//            TLX valid/select outputs).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface afu_tlx_cmd_arb_if #(
    parameter int NREQ  = 4,
    parameter int SEL_W = 2
);
    logic                 tlx_afu_ready;
    logic [2:0]           tlx_afu_cmd_resp_initial_credit;
    logic [4:0]           tlx_afu_data_initial_credit;
    logic                 tlx_afu_cmd_credit;
    logic                 tlx_afu_cmd_data_credit;
    logic [NREQ-1:0]      req_valid;
    logic [3*NREQ-1:0]    req_beats;
    logic [NREQ-1:0]      req_grant;
    logic [NREQ-1:0]      req_data_ack;
    logic                 afu_tlx_cmd_valid;
    logic [SEL_W-1:0]     cmd_sel;
    logic                 afu_tlx_cdata_valid;
    logic [SEL_W-1:0]     cdata_sel;
    logic [3:0]           cmd_credit_cnt;
    logic [5:0]           data_credit_cnt;
    logic                 credit_err;

    // master: the arbiter
    modport master (
        input  tlx_afu_ready, tlx_afu_cmd_resp_initial_credit, tlx_afu_data_initial_credit,
               tlx_afu_cmd_credit, tlx_afu_cmd_data_credit, req_valid, req_beats,
        output req_grant, req_data_ack, afu_tlx_cmd_valid, cmd_sel,
               afu_tlx_cdata_valid, cdata_sel, cmd_credit_cnt, data_credit_cnt, credit_err
    );

    modport slave (
        output tlx_afu_ready, tlx_afu_cmd_resp_initial_credit, tlx_afu_data_initial_credit,
               tlx_afu_cmd_credit, tlx_afu_cmd_data_credit, req_valid, req_beats,
        input  req_grant, req_data_ack, afu_tlx_cmd_valid, cmd_sel,
               afu_tlx_cdata_valid, cdata_sel, cmd_credit_cnt, data_credit_cnt, credit_err
    );
endinterface

`default_nettype wire

// File: rtl/afu_tlx_cmd_arb.sv
// ============================================================================
// Module   : afu_tlx_cmd_arb
// Brief    : Round-robin arbiter and credit scheduler sequencing AFU engine
//            commands and their write-data beats onto the TLX transmit port.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module afu_tlx_cmd_arb #(
    parameter int NREQ  = 4,
    parameter int SEL_W = 2
) (
    input  wire               ha_pclock,
    input  wire               reset,
    afu_tlx_cmd_arb_if.master bus
);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [2:0] C_MAX_BEATS = 3'd4;

    state_t            r_state, w_state_nxt;
    logic [SEL_W-1:0]  r_rr_ptr, w_rr_ptr_nxt;
    logic [SEL_W-1:0]  r_data_idx, w_data_idx_nxt;
    logic [2:0]        r_beats_left, w_beats_left_nxt;
    logic [3:0]        r_cmd_cnt, w_cmd_cnt_nxt;
    logic [5:0]        r_data_cnt, w_data_cnt_nxt;
    logic [2:0]        r_cmd_max, w_cmd_max_nxt;
    logic [4:0]        r_data_max, w_data_max_nxt;
    logic              r_err, w_err_nxt;
    logic [NREQ-1:0]   r_grant, w_grant_nxt;
    logic [NREQ-1:0]   r_ack, w_ack_nxt;
    logic              r_cmd_valid, w_cmd_valid_nxt;
    logic              r_cdata_valid, w_cdata_valid_nxt;
    logic [SEL_W-1:0]  r_cmd_sel, w_cmd_sel_nxt;
    logic [SEL_W-1:0]  r_cdata_sel, w_cdata_sel_nxt;

    logic [NREQ-1:0]   w_avail;
    logic [SEL_W-1:0]  w_scan_idx;
    logic              w_found;
    logic [SEL_W-1:0]  w_idx;
    logic [2:0]        w_beats_raw;
    logic              w_beats_bad;
    logic [2:0]        w_beats;
    logic              w_issue;
    logic [3:0]        w_cmd_sum;
    logic [5:0]        w_data_sum;

    // The requester granted last cycle still shows req_valid this cycle.
    assign w_avail = bus.req_valid & ~r_grant;

    always_comb begin
        w_found    = 1'b0;
        w_idx      = '0;
        w_scan_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_scan_idx = SEL_W'((int'(r_rr_ptr) + k) % NREQ);
            if (!w_found && w_avail[w_scan_idx]) begin
                w_found = 1'b1;
                w_idx   = w_scan_idx;
            end
        end
    end

    always_comb begin
        w_beats_raw = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_idx == SEL_W'(i))
                w_beats_raw = bus.req_beats[3*i +: 3];
        end
    end

    assign w_beats_bad = (w_beats_raw > C_MAX_BEATS);
    assign w_beats     = w_beats_bad ? C_MAX_BEATS : w_beats_raw;

    // The candidate holds the slot while short of credit: no skipping.
    assign w_issue = (r_state == ST_RUN) && bus.tlx_afu_ready && w_found &&
                     (r_cmd_cnt != 4'd0) && (r_data_cnt >= {3'b000, w_beats});

    // Cannot underflow: consumption only happens when credit was available.
    assign w_cmd_sum  = r_cmd_cnt - {3'b000, w_issue} + {3'b000, bus.tlx_afu_cmd_credit};
    assign w_data_sum = r_data_cnt - {3'b000, (w_issue ? w_beats : 3'd0)}
                        + {5'b00000, bus.tlx_afu_cmd_data_credit};

    always_comb begin
        w_state_nxt       = r_state;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_data_idx_nxt    = r_data_idx;
        w_beats_left_nxt  = r_beats_left;
        w_cmd_cnt_nxt     = r_cmd_cnt;
        w_data_cnt_nxt    = r_data_cnt;
        w_cmd_max_nxt     = r_cmd_max;
        w_data_max_nxt    = r_data_max;
        w_err_nxt         = r_err;
        w_grant_nxt       = '0;
        w_ack_nxt         = '0;
        w_cmd_valid_nxt   = 1'b0;
        w_cdata_valid_nxt = 1'b0;
        w_cmd_sel_nxt     = r_cmd_sel;
        w_cdata_sel_nxt   = r_cdata_sel;

        if (r_state != ST_WAIT) begin
            if (w_cmd_sum > {1'b0, r_cmd_max}) begin
                w_cmd_cnt_nxt = {1'b0, r_cmd_max};
                w_err_nxt     = 1'b1;
            end else begin
                w_cmd_cnt_nxt = w_cmd_sum;
            end
            if (w_data_sum > {1'b0, r_data_max}) begin
                w_data_cnt_nxt = {1'b0, r_data_max};
                w_err_nxt      = 1'b1;
            end else begin
                w_data_cnt_nxt = w_data_sum;
            end
        end

        case (r_state)
            ST_WAIT: begin
                if (bus.tlx_afu_ready) begin
                    w_cmd_cnt_nxt  = {1'b0, bus.tlx_afu_cmd_resp_initial_credit};
                    w_data_cnt_nxt = {1'b0, bus.tlx_afu_data_initial_credit};
                    w_cmd_max_nxt  = bus.tlx_afu_cmd_resp_initial_credit;
                    w_data_max_nxt = bus.tlx_afu_data_initial_credit;
                    w_state_nxt    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_issue) begin
                    w_cmd_valid_nxt    = 1'b1;
                    w_cmd_sel_nxt      = w_idx;
                    w_grant_nxt[w_idx] = 1'b1;
                    w_rr_ptr_nxt       = w_idx;
                    if (w_beats_bad)
                        w_err_nxt = 1'b1;
                    if (w_beats != 3'd0) begin
                        w_state_nxt      = ST_DATA;
                        w_beats_left_nxt = w_beats;
                        w_data_idx_nxt   = w_idx;
                    end
                end
            end
            ST_DATA: begin
                w_cdata_valid_nxt     = 1'b1;
                w_cdata_sel_nxt       = r_data_idx;
                w_ack_nxt[r_data_idx] = 1'b1;
                w_beats_left_nxt      = r_beats_left - 3'd1;
                if (r_beats_left == 3'd1)
                    w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_WAIT;
        endcase
    end

    always_ff @(posedge ha_pclock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_WAIT;
            r_rr_ptr      <= '0;
            r_data_idx    <= '0;
            r_beats_left  <= '0;
            r_cmd_cnt     <= '0;
            r_data_cnt    <= '0;
            r_cmd_max     <= '0;
            r_data_max    <= '0;
            r_err         <= 1'b0;
            r_grant       <= '0;
            r_ack         <= '0;
            r_cmd_valid   <= 1'b0;
            r_cdata_valid <= 1'b0;
            r_cmd_sel     <= '0;
            r_cdata_sel   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_data_idx    <= w_data_idx_nxt;
            r_beats_left  <= w_beats_left_nxt;
            r_cmd_cnt     <= w_cmd_cnt_nxt;
            r_data_cnt    <= w_data_cnt_nxt;
            r_cmd_max     <= w_cmd_max_nxt;
            r_data_max    <= w_data_max_nxt;
            r_err         <= w_err_nxt;
            r_grant       <= w_grant_nxt;
            r_ack         <= w_ack_nxt;
            r_cmd_valid   <= w_cmd_valid_nxt;
            r_cdata_valid <= w_cdata_valid_nxt;
            r_cmd_sel     <= w_cmd_sel_nxt;
            r_cdata_sel   <= w_cdata_sel_nxt;
        end
    end

    assign bus.req_grant           = r_grant;
    assign bus.req_data_ack        = r_ack;
    assign bus.afu_tlx_cmd_valid   = r_cmd_valid;
    assign bus.cmd_sel             = r_cmd_sel;
    assign bus.afu_tlx_cdata_valid = r_cdata_valid;
    assign bus.cdata_sel           = r_cdata_sel;
    assign bus.cmd_credit_cnt      = r_cmd_cnt;
    assign bus.data_credit_cnt     = r_data_cnt;
    assign bus.credit_err          = r_err;

endmodule

`default_nettype wire

// File: tb/tb_afu_tlx_cmd_arb.sv
// ============================================================================
// Module   : tb_afu_tlx_cmd_arb
// Brief    : Directed self-checking bench for afu_tlx_cmd_arb with a
//            command/data scoreboard.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_afu_tlx_cmd_arb;
    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    logic ha_pclock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   exp_cmd[$];
    int   exp_data[$];

    afu_tlx_cmd_arb_if #(.NREQ(NREQ), .SEL_W(SEL_W)) bus();

    afu_tlx_cmd_arb #(.NREQ(NREQ), .SEL_W(SEL_W)) dut (
        .ha_pclock (ha_pclock),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 ha_pclock = ~ha_pclock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_cmd_valid"},   32'(bus.afu_tlx_cmd_valid),   0);
        chk({tag, "_cdata_valid"}, 32'(bus.afu_tlx_cdata_valid), 0);
        chk({tag, "_grant"},       32'(bus.req_grant),           0);
        chk({tag, "_ack"},         32'(bus.req_data_ack),        0);
        chk({tag, "_cmd_cnt"},     32'(bus.cmd_credit_cnt),      0);
        chk({tag, "_data_cnt"},    32'(bus.data_credit_cnt),     0);
        chk({tag, "_err"},         32'(bus.credit_err),          0);
    endtask

    // One clock with optional credit-return pulses; scoreboard the outputs and
    // let requesters drop req_valid once granted.
    task automatic tick(input logic c, input logic d);
        int e;
        bus.tlx_afu_cmd_credit      = c;
        bus.tlx_afu_cmd_data_credit = d;
        @(posedge ha_pclock);
        #1;
        bus.tlx_afu_cmd_credit      = 1'b0;
        bus.tlx_afu_cmd_data_credit = 1'b0;
        if (bus.afu_tlx_cmd_valid) begin
            if (exp_cmd.size() == 0) begin
                chk("cmd_unexpected", 32'(bus.afu_tlx_cmd_valid), 0);
            end else begin
                e = exp_cmd.pop_front();
                chk("sb_cmd_sel", 32'(bus.cmd_sel), e);
                chk("sb_grant", 32'(bus.req_grant), 32'(1) << e);
            end
        end else begin
            chk("sb_grant_idle", 32'(bus.req_grant), 0);
        end
        if (bus.afu_tlx_cdata_valid) begin
            if (exp_data.size() == 0) begin
                chk("data_unexpected", 32'(bus.afu_tlx_cdata_valid), 0);
            end else begin
                e = exp_data.pop_front();
                chk("sb_cdata_sel", 32'(bus.cdata_sel), e);
                chk("sb_ack", 32'(bus.req_data_ack), 32'(1) << e);
            end
        end else begin
            chk("sb_ack_idle", 32'(bus.req_data_ack), 0);
        end
        bus.req_valid = bus.req_valid & ~bus.req_grant;
    endtask

    task automatic step();
        tick(1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        bus.tlx_afu_ready                   = 1'b0;
        bus.tlx_afu_cmd_resp_initial_credit = 3'd4;
        bus.tlx_afu_data_initial_credit     = 5'd8;
        bus.tlx_afu_cmd_credit              = 1'b0;
        bus.tlx_afu_cmd_data_credit         = 1'b0;
        bus.req_valid                       = '0;
        bus.req_beats                       = '0;
        repeat (2) step();
        chk_reset_state("reset");

        // WAIT: pending request from req3 must not issue before ready
        @(negedge ha_pclock);
        reset = 1'b0;
        bus.req_valid[3] = 1'b1;
        exp_cmd.push_back(3);
        repeat (2) begin
            step();
            chk("wait_no_cmd", 32'(bus.afu_tlx_cmd_valid), 0);
            chk("wait_cmd_cnt", 32'(bus.cmd_credit_cnt), 0);
        end
        bus.tlx_afu_ready = 1'b1;
        step();
        chk("load_cmd_cnt", 32'(bus.cmd_credit_cnt), 4);
        chk("load_data_cnt", 32'(bus.data_credit_cnt), 8);
        chk("load_no_cmd", 32'(bus.afu_tlx_cmd_valid), 0);
        // req3 issues with a same-cycle command credit return
        tick(1'b1, 1'b0);
        chk("prime_cmd_valid", 32'(bus.afu_tlx_cmd_valid), 1);
        chk("prime_cmd_cnt", 32'(bus.cmd_credit_cnt), 4);

        // All four zero-beat requests: rr from req3 gives 0,1,2,3
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) exp_cmd.push_back(i);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_cmd_valid", 32'(bus.afu_tlx_cmd_valid), 1);
            chk("rr_cmd_cnt", 32'(bus.cmd_credit_cnt), 32'(3 - i));
        end
        bus.req_valid[0] = 1'b1;
        exp_cmd.push_back(0);
        repeat (2) begin
            step();
            chk("nocred_stall", 32'(bus.afu_tlx_cmd_valid), 0);
        end
        tick(1'b1, 1'b0);
        chk("ret_no_cmd_yet", 32'(bus.afu_tlx_cmd_valid), 0);
        chk("ret_cmd_cnt", 32'(bus.cmd_credit_cnt), 1);
        step();
        chk("ret_grant0", 32'(bus.req_grant), 1);
        chk("ret_cmd_cnt0", 32'(bus.cmd_credit_cnt), 0);
        repeat (4) tick(1'b1, 1'b0);
        chk("refill_cmd_cnt", 32'(bus.cmd_credit_cnt), 4);
        chk("refill_err", 32'(bus.credit_err), 0);

        // req1 with 4 beats; req2 queued behind the burst
        bus.req_beats[5:3] = 3'd4;
        bus.req_valid[1]   = 1'b1;
        exp_cmd.push_back(1);
        repeat (4) exp_data.push_back(1);
        step();
        chk("b4_cmd_valid", 32'(bus.afu_tlx_cmd_valid), 1);
        chk("b4_data_cnt", 32'(bus.data_credit_cnt), 4);
        chk("b4_cmd_cnt", 32'(bus.cmd_credit_cnt), 3);
        bus.req_valid[2] = 1'b1;
        exp_cmd.push_back(2);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("b4_beat_valid", 32'(bus.afu_tlx_cdata_valid), 1);
            chk("b4_beat_ack", 32'(bus.req_data_ack), 2);
            chk("b4_no_cmd", 32'(bus.afu_tlx_cmd_valid), 0);
        end
        step();
        chk("b4_next_cmd", 32'(bus.afu_tlx_cmd_valid), 1);
        chk("b4_next_sel", 32'(bus.cmd_sel), 2);
        chk("b4_burst_end", 32'(bus.afu_tlx_cdata_valid), 0);

        // req3 2-beat burst brings data credits down to 2
        bus.req_beats[11:9] = 3'd2;
        bus.req_valid[3]    = 1'b1;
        exp_cmd.push_back(3);
        repeat (2) exp_data.push_back(3);
        step();
        chk("b2_data_cnt", 32'(bus.data_credit_cnt), 2);
        repeat (2) step();

        // req0 needs 4 beats with only 2 credits: req1 must wait behind it
        bus.req_beats[2:0] = 3'd4;
        bus.req_beats[5:3] = 3'd0;
        bus.req_valid[0]   = 1'b1;
        bus.req_valid[1]   = 1'b1;
        exp_cmd.push_back(0);
        exp_cmd.push_back(1);
        repeat (4) exp_data.push_back(0);
        repeat (2) begin
            step();
            chk("starve_stall", 32'(bus.afu_tlx_cmd_valid), 0);
        end
        tick(1'b1, 1'b1);
        chk("starve_stall_r1", 32'(bus.afu_tlx_cmd_valid), 0);
        tick(1'b0, 1'b1);
        chk("starve_stall_r2", 32'(bus.afu_tlx_cmd_valid), 0);
        chk("starve_data_cnt", 32'(bus.data_credit_cnt), 4);
        step();
        chk("starve_grant0", 32'(bus.req_grant), 1);
        chk("starve_data_cnt0", 32'(bus.data_credit_cnt), 0);
        repeat (4) step();
        step();
        chk("starve_grant1", 32'(bus.req_grant), 2);
        chk("starve_cmd_cnt", 32'(bus.cmd_credit_cnt), 0);
        repeat (2) tick(1'b1, 1'b1);
        repeat (2) tick(1'b0, 1'b1);
        chk("refill2_cmd", 32'(bus.cmd_credit_cnt), 2);
        chk("refill2_data", 32'(bus.data_credit_cnt), 4);

        // Issue with same-cycle returns of one cmd and one data credit
        bus.req_beats[8:6] = 3'd2;
        bus.req_valid[2]   = 1'b1;
        exp_cmd.push_back(2);
        repeat (2) exp_data.push_back(2);
        tick(1'b1, 1'b1);
        chk("same_cmd_valid", 32'(bus.afu_tlx_cmd_valid), 1);
        chk("same_cmd_cnt", 32'(bus.cmd_credit_cnt), 2);
        chk("same_data_cnt", 32'(bus.data_credit_cnt), 3);
        repeat (2) step();

        // Saturation at the loaded maximum
        repeat (2) tick(1'b1, 1'b0);
        chk("sat_pre_cnt", 32'(bus.cmd_credit_cnt), 4);
        chk("sat_pre_err", 32'(bus.credit_err), 0);
        tick(1'b1, 1'b0);
        chk("sat_cnt", 32'(bus.cmd_credit_cnt), 4);
        chk("sat_err", 32'(bus.credit_err), 1);
        step();
        chk("sat_err_sticky", 32'(bus.credit_err), 1);

        // Asynchronous reset in the middle of a 3-beat burst
        bus.req_beats[5:3] = 3'd3;
        bus.req_valid[1]   = 1'b1;
        exp_cmd.push_back(1);
        repeat (3) exp_data.push_back(1);
        step();
        chk("mid_cmd_valid", 32'(bus.afu_tlx_cmd_valid), 1);
        step();
        chk("mid_beat", 32'(bus.afu_tlx_cdata_valid), 1);
        #2 reset = 1'b1;
        #1;
        chk_reset_state("async_rst");
        exp_data.delete();
        bus.req_valid = '0;
        repeat (2) step();
        chk_reset_state("rst_hold");

        // Restart; beats=7 is treated as 4 and flags an error
        @(negedge ha_pclock);
        reset = 1'b0;
        step();
        chk("reload_cmd_cnt", 32'(bus.cmd_credit_cnt), 4);
        chk("reload_data_cnt", 32'(bus.data_credit_cnt), 8);
        bus.req_beats      = '0;
        bus.req_beats[2:0] = 3'd7;
        bus.req_valid[0]   = 1'b1;
        exp_cmd.push_back(0);
        repeat (4) exp_data.push_back(0);
        step();
        chk("b7_data_cnt", 32'(bus.data_credit_cnt), 4);
        chk("b7_err", 32'(bus.credit_err), 1);
        repeat (4) step();
        step();
        chk("b7_burst_end", 32'(bus.afu_tlx_cdata_valid), 0);

        // Ready drop blocks issue; re-rise does not reload credits
        bus.req_beats     = '0;
        bus.tlx_afu_ready = 1'b0;
        bus.req_valid[3]  = 1'b1;
        exp_cmd.push_back(3);
        repeat (2) begin
            step();
            chk("nrdy_stall", 32'(bus.afu_tlx_cmd_valid), 0);
        end
        chk("nrdy_cmd_cnt", 32'(bus.cmd_credit_cnt), 3);
        bus.tlx_afu_ready = 1'b1;
        step();
        chk("rdy_cmd_valid", 32'(bus.afu_tlx_cmd_valid), 1);
        chk("rdy_cmd_cnt", 32'(bus.cmd_credit_cnt), 2);
        chk("rdy_no_reload", 32'(bus.data_credit_cnt), 4);

        chk("cmd_queue_drained", 32'(exp_cmd.size()), 0);
        chk("data_queue_drained", 32'(exp_data.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
